dmem_arbiter: RTL

Single-port data-RAM arbiter and load/store lane controller placed between the pipeline's memory stage and the data RAM. Shares the one RAM port between the CPU (load/store from MEM stage) and a secondary DMA/loader requester, generates byte-lane write strobes and load sign/zero extension from funct3, and tracks which requester owns the in-flight read. Optional starvation guard stalls the CPU one cycle so a waiting DMA request cannot be locked out.

---
 rtl/dmem_arbiter_pkg.sv | 12 +
 rtl/dmem_arbiter_if.sv | 40 ++++
 rtl/dmem_lane_align.sv | 36 +++
 rtl/dmem_arbiter.sv | 81 ++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// dmem_arb_pkg: funct3 encodings and read-owner state shared by the data-RAM arbiter
package dmem_arb_pkg;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DMA} owner_e;
endpackage

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, DMA and RAM-port signals of the data-RAM arbiter (slave = arbiter side)
interface dmem_arbiter_if #(parameter int ADDR_W = 10);
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [2:0]        cpu_funct3;
  logic              cpu_stall;
  logic              cpu_misalign;
  logic [31:0]       cpu_rdata;
  logic              cpu_rvalid;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [31:0]       dma_wdata;
  logic              dma_gnt;
  logic [31:0]       dma_rdata;
  logic              dma_rvalid;
  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [31:0]       ram_rdata;
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    output cpu_stall, cpu_misalign, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_funct3,
    input  cpu_stall, cpu_misalign, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store strobes/replication, misalign detect and load byte/half extraction with extension
module dmem_lane_align
  import dmem_arb_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] rdata,
  output logic [3:0]  we_mask,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  output logic [31:0] rdata_ext
);
  logic is_b, is_h;
  logic [7:0]  b;
  logic [15:0] h;
  // access size from funct3 drives lane strobes, replicated data and alignment check
  always_comb begin
    is_b      = funct3 == F3_SB || funct3 == F3_LBU;
    is_h      = funct3 == F3_SH || funct3 == F3_LHU;
    we_mask   = is_b ? 4'b0001 << off : is_h ? 4'b0011 << {off[1], 1'b0} : 4'b1111;
    wdata_rep = is_b ? {4{wdata[7:0]}} : is_h ? {2{wdata[15:0]}} : wdata;
    misalign  = is_h ? off[0] : !is_b && off != 2'b00;
  end
  // pick the addressed lane of the returned word and extend per the captured load type
  always_comb begin
    b         = rdata[{ld_off, 3'b000} +: 8];
    h         = rdata[{ld_off[1], 4'b0000} +: 16];
    rdata_ext = ld_funct3 == F3_LB  ? {{24{b[7]}}, b} :
                ld_funct3 == F3_LBU ? {24'b0, b} :
                ld_funct3 == F3_LH  ? {{16{h[15]}}, h} :
                ld_funct3 == F3_LHU ? {16'b0, h} : rdata;
  end
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: single-port data-RAM arbiter (CPU priority, DMA secondary); DMEM_ARB_STARVE_GUARD_EN adds DMA starvation guard
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 8
) (
  input logic          clk,
  input logic          reset,
  dmem_arbiter_if.slave bus
);
  owner_e      own, own_nx;
  logic [2:0]  ld_f3;
  logic [1:0]  ld_off;
  logic [3:0]  we_mask;
  logic [31:0] wdata_rep, rdata_ext;
  logic        misalign, cpu_ok, cpu_gnt, dma_gnt, force_dma;
  logic        unused_addr;
  dmem_lane_align u_lane (
    .funct3    (bus.cpu_funct3),
    .off       (bus.cpu_addr[1:0]),
    .wdata     (bus.cpu_wdata),
    .ld_funct3 (ld_f3),
    .ld_off    (ld_off),
    .rdata     (bus.ram_rdata),
    .we_mask   (we_mask),
    .wdata_rep (wdata_rep),
    .misalign  (misalign),
    .rdata_ext (rdata_ext)
  );
  assign cpu_ok      = bus.cpu_req & ~misalign;
  assign unused_addr = |bus.cpu_addr[31:ADDR_W+2];
`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;
  assign force_dma = cpu_ok & bus.dma_req & (starve == CW'(STARVE_MAX));
  // count cycles a pending DMA request loses to the CPU; any grant or idle DMA clears it
  always_ff @(posedge clk or posedge reset)
    if (reset) starve <= '0;
    else if (dma_gnt | ~bus.dma_req) starve <= '0;
    else starve <= starve + CW'(1);
`else
  logic unused_starve;
  assign force_dma     = 1'b0;
  assign unused_starve = |STARVE_MAX;
`endif
  // grant the single RAM slot and steer address, strobes and data from the winner
  always_comb begin
    cpu_gnt          = cpu_ok & ~force_dma;
    dma_gnt          = bus.dma_req & ~cpu_gnt;
    bus.dma_gnt      = dma_gnt;
    bus.cpu_stall    = force_dma;
    bus.cpu_misalign = bus.cpu_req & misalign;
    bus.ram_en       = cpu_gnt | dma_gnt;
    bus.ram_we       = cpu_gnt ? (bus.cpu_we ? we_mask : 4'b0000) : (dma_gnt & bus.dma_we) ? 4'b1111 : 4'b0000;
    bus.ram_addr     = cpu_gnt ? bus.cpu_addr[ADDR_W+1:2] : dma_gnt ? bus.dma_addr : '0;
    bus.ram_wdata    = cpu_gnt ? wdata_rep : bus.dma_wdata;
  end
  // owner of the in-flight read plus the CPU load type/offset needed to extract it next cycle
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      own    <= OWN_NONE;
      ld_f3  <= '0;
      ld_off <= '0;
    end else begin
      own <= own_nx;
      if (own_nx == OWN_CPU) begin
        ld_f3  <= bus.cpu_funct3;
        ld_off <= bus.cpu_addr[1:0];
      end
    end
  // whoever received a read grant this cycle owns next cycle's RAM data
  always_comb own_nx = (cpu_gnt & ~bus.cpu_we) ? OWN_CPU : (dma_gnt & ~bus.dma_we) ? OWN_DMA : OWN_NONE;
  // route returned data to its owner as a one-cycle valid pulse
  always_comb begin
    bus.cpu_rvalid = own == OWN_CPU;
    bus.dma_rvalid = own == OWN_DMA;
    bus.cpu_rdata  = rdata_ext;
    bus.dma_rdata  = bus.ram_rdata;
  end
endmodule
